// File: rtl/cpu_types_pkg.sv
// Shared CPU/ALU types: ALU operation codes, input sequencer states and
// the operand sign-extension helper used by the board front-end.
package cpu_types_pkg;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'h0,
      ALU_SUB   = 4'h1,
      ALU_AND   = 4'h2,
      ALU_OR    = 4'h3,
      ALU_XOR   = 4'h4,
      ALU_NOR   = 4'h5,
      ALU_SLL   = 4'h6,
      ALU_SRL   = 4'h7,
      ALU_SRA   = 4'h8,
      ALU_SLT   = 4'h9,
      ALU_SLTU  = 4'hA,
      ALU_LUI   = 4'hB,
      ALU_PASSA = 4'hC,
      ALU_PASSB = 4'hD,
      ALU_MUL   = 4'hE,
      ALU_NOP   = 4'hF
   } aluop_t;

   typedef enum logic [1:0] {
      LOAD_A  = 2'd0,
      LOAD_B  = 2'd1,
      LOAD_OP = 2'd2,
      HOLD    = 2'd3
   } seq_state_t;

   localparam int KEY_ADVANCE = 0;
   localparam int KEY_BACK    = 1;
   localparam int KEY_SWAP    = 2;
   localparam int KEY_CLEAR   = 3;

   // sw[16] is the sign of the 16-bit switch value
   function automatic logic [31:0] sign_ext_operand(input logic [16:0] value);
      return {{16{value[16]}}, value[15:0]};
   endfunction

endpackage

// File: rtl/alu_input_sequencer_key_debounce.sv
// One push-button: 2-flop synchroniser, stable-level debounce counter and
// a single-cycle press pulse on each accepted high-to-low transition.
module key_debounce #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic CLK,
   input  logic RST,
   input  logic key_n_in,
   output logic stable_out,
   output logic press_out
);

   logic             sync_1;
   logic             sync_2;
   logic             stable;
   logic             stable_prev;
   logic [CNT_W-1:0] count;

   // synchronise, then accept a new level only after it persists long enough
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         sync_1      <= 1'b1;
         sync_2      <= 1'b1;
         stable      <= 1'b1;
         stable_prev <= 1'b1;
         count       <= '0;
      end else begin
         sync_1      <= key_n_in;
         sync_2      <= sync_1;
         stable_prev <= stable;
         if (sync_2 != stable) begin
            if (count == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
               stable <= sync_2;
               count  <= '0;
            end else begin
               count  <= count + CNT_W'(1);
            end
         end else begin
            count <= '0;
         end
      end
   end

   assign stable_out = stable;
   assign press_out  = stable_prev & ~stable;

endmodule

// File: rtl/alu_input_sequencer.sv
// Board front-end for the ALU wrapper: debounced keys step a load-A /
// load-B / load-op sequence and hold latched operands for the ALU.
module alu_input_sequencer
   import cpu_types_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int CNT_W           = 20
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [3:0]  key_n,
   input  logic [17:0] sw,
   output logic [31:0] portA,
   output logic [31:0] portB,
   output aluop_t      aluOp,
   output logic        op_valid,
   output logic        op_strobe,
   output seq_state_t  state
);

   logic [3:0]  press;
   logic [3:0]  stable;
   logic [31:0] ext;
   logic        unused_inputs;

   seq_state_t  state_nx;
   logic [31:0] port_a_nx;
   logic [31:0] port_b_nx;
   aluop_t      alu_op_nx;
   logic        strobe_nx;

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_key
         key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
         ) u_debounce (
            .CLK       (CLK),
            .RST       (RST),
            .key_n_in  (key_n[k]),
            .stable_out(stable[k]),
            .press_out (press[k])
         );
      end
   endgenerate

   assign ext           = sign_ext_operand(sw[16:0]);
   assign unused_inputs = ^{sw[17], stable};

   // one key acts per cycle: clear, then back, then swap, then advance
   always_comb begin
      state_nx  = state;
      port_a_nx = portA;
      port_b_nx = portB;
      alu_op_nx = aluOp;
      strobe_nx = 1'b0;
      if (press[KEY_CLEAR]) begin
         state_nx  = LOAD_A;
         port_a_nx = 32'h0;
         port_b_nx = 32'h0;
         alu_op_nx = aluop_t'(4'h0);
      end else if (press[KEY_BACK]) begin
         case (state)
            LOAD_A:  state_nx = LOAD_A;
            LOAD_B:  state_nx = LOAD_A;
            LOAD_OP: state_nx = LOAD_B;
            HOLD:    state_nx = LOAD_OP;
            default: state_nx = LOAD_A;
         endcase
      end else if (press[KEY_SWAP]) begin
         if (state == HOLD) begin
            port_a_nx = portB;
            port_b_nx = portA;
            strobe_nx = ~op_strobe;
         end else begin
            state_nx = state;
         end
      end else if (press[KEY_ADVANCE]) begin
         case (state)
            LOAD_A: begin
               port_a_nx = ext;
               state_nx  = LOAD_B;
            end
            LOAD_B: begin
               port_b_nx = ext;
               state_nx  = LOAD_OP;
            end
            LOAD_OP: begin
               alu_op_nx = aluop_t'(sw[3:0]);
               state_nx  = HOLD;
               strobe_nx = ~op_strobe;
            end
            HOLD:    state_nx = LOAD_A;
            default: state_nx = LOAD_A;
         endcase
      end else begin
         state_nx = state;
      end
   end

   // all outputs are registered together with the sequencer state
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= LOAD_A;
         portA     <= 32'h0;
         portB     <= 32'h0;
         aluOp     <= aluop_t'(4'h0);
         op_valid  <= 1'b0;
         op_strobe <= 1'b0;
      end else begin
         state     <= state_nx;
         portA     <= port_a_nx;
         portB     <= port_b_nx;
         aluOp     <= alu_op_nx;
         op_valid  <= (state_nx == HOLD);
         op_strobe <= strobe_nx;
      end
   end

endmodule
